// File: rtl/d_hazard_scoreboard.sv
// d_hazard_scoreboard: decode-stage register file, Tnew scoreboard, operand
// forwarding and stall generation (data hazards and multiply/divide busy).
module d_hazard_scoreboard #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NSTAGE  = 3,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [AW-1:0]        d_rs,
  input  logic [AW-1:0]        d_rt,
  input  logic                 d_rs_use,
  input  logic                 d_rt_use,
  input  logic [1:0]           d_rs_tuse,
  input  logic [1:0]           d_rt_tuse,
  input  logic [AW-1:0]        d_dst,
  input  logic [1:0]           d_tnew,
  input  logic                 d_md,
  input  logic                 d_md_start,
  input  logic                 d_md_div,
  input  logic [NSTAGE*DW-1:0] fwd_data,
  input  logic                 w_we,
  input  logic [AW-1:0]        w_addr,
  input  logic [DW-1:0]        w_data,
  output logic [DW-1:0]        rs_data,
  output logic [DW-1:0]        rt_data,
  output logic                 stall,
  output logic                 md_busy
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned CW   = $clog2(DIV_LAT + 1);
  localparam int unsigned SIW  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  // Index 0 of the scoreboard arrays is stage 1 (E), the youngest entry.
  logic [DW-1:0]               grf_q [NREG];
  logic [NSTAGE-1:0]           sb_vld_q, sb_vld_d;
  logic [AW-1:0]               sb_dst_q [NSTAGE];
  logic [AW-1:0]               sb_dst_d [NSTAGE];
  logic [1:0]                  sb_tnew_q [NSTAGE];
  logic [1:0]                  sb_tnew_d [NSTAGE];
  logic [CW-1:0]               md_cnt_q, md_cnt_d;

  logic [NSTAGE-1:0][DW-1:0]   fwd_arr;
  logic                        rs_hit, rt_hit;
  logic [1:0]                  rs_tnew, rt_tnew;
  logic [DW-1:0]               rs_fwd, rt_fwd;
  logic [DW-1:0]               rs_grf, rt_grf;
  logic                        data_stall;

  assign fwd_arr = fwd_data;

  // Youngest scoreboard match per source operand (lowest stage wins).
  always_comb begin
    rs_hit  = 1'b0;
    rs_tnew = 2'd0;
    rs_fwd  = '0;
    rt_hit  = 1'b0;
    rt_tnew = 2'd0;
    rt_fwd  = '0;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      if (sb_vld_q[SIW'(i)] && (d_rs != '0) && (sb_dst_q[SIW'(i)] == d_rs)) begin
        rs_hit  = 1'b1;
        rs_tnew = sb_tnew_q[SIW'(i)];
        rs_fwd  = fwd_arr[SIW'(i)];
      end
      if (sb_vld_q[SIW'(i)] && (d_rt != '0) && (sb_dst_q[SIW'(i)] == d_rt)) begin
        rt_hit  = 1'b1;
        rt_tnew = sb_tnew_q[SIW'(i)];
        rt_fwd  = fwd_arr[SIW'(i)];
      end
    end
  end

  // Register file read with same-cycle write-through; r0 always reads zero.
  always_comb begin
    rs_grf = grf_q[d_rs];
    rt_grf = grf_q[d_rt];
    if (d_rs == '0) begin
      rs_grf = '0;
    end else if (w_we && (w_addr == d_rs)) begin
      rs_grf = w_data;
    end
    if (d_rt == '0) begin
      rt_grf = '0;
    end else if (w_we && (w_addr == d_rt)) begin
      rt_grf = w_data;
    end
  end

  // Ready producers forward; otherwise the register-file path is used.
  assign rs_data = (rs_hit && (rs_tnew == 2'd0)) ? rs_fwd : rs_grf;
  assign rt_data = (rt_hit && (rt_tnew == 2'd0)) ? rt_fwd : rt_grf;

  assign data_stall = d_valid &&
                      ((d_rs_use && rs_hit && (rs_tnew > d_rs_tuse)) ||
                       (d_rt_use && rt_hit && (rt_tnew > d_rt_tuse)));
  assign md_busy    = (md_cnt_q != '0);
  assign stall      = data_stall || (d_valid && d_md && md_busy);

  // Scoreboard shift: D enters stage 1 unless stalled, older entries age.
  always_comb begin
    sb_vld_d     = '0;
    sb_vld_d[0]  = d_valid && !stall && (d_dst != '0);
    sb_dst_d[0]  = d_dst;
    sb_tnew_d[0] = d_tnew;
    for (int i = 1; i < int'(NSTAGE); i++) begin
      sb_vld_d[SIW'(i)]  = sb_vld_q[SIW'(i - 1)];
      sb_dst_d[SIW'(i)]  = sb_dst_q[SIW'(i - 1)];
      sb_tnew_d[SIW'(i)] = (sb_tnew_q[SIW'(i - 1)] == 2'd0) ? 2'd0
                                                           : sb_tnew_q[SIW'(i - 1)] - 2'd1;
    end
  end

  // Multiply/divide busy counter: load on an accepted start, else count down.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_valid && d_md_start && !stall) begin
      md_cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  // Scoreboard and counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld_q <= '0;
      md_cnt_q <= '0;
      for (int i = 0; i < int'(NSTAGE); i++) begin
        sb_dst_q[SIW'(i)]  <= '0;
        sb_tnew_q[SIW'(i)] <= 2'd0;
      end
    end else begin
      sb_vld_q <= sb_vld_d;
      md_cnt_q <= md_cnt_d;
      for (int i = 0; i < int'(NSTAGE); i++) begin
        sb_dst_q[SIW'(i)]  <= sb_dst_d[SIW'(i)];
        sb_tnew_q[SIW'(i)] <= sb_tnew_d[SIW'(i)];
      end
    end
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        grf_q[AW'(i)] <= '0;
      end
    end else if (w_we && (w_addr != '0)) begin
      grf_q[w_addr] <= w_data;
    end
  end

endmodule

// File: doc/d_hazard_scoreboard.md
# d_hazard_scoreboard

Parametrised decode-stage operand unit for the five-stage MIPS pipeline. It holds the general register file (GRF), tracks in-flight destination registers in an internal Tnew scoreboard, and forwards results from later stages into D. It raises `stall` on Tuse/Tnew conflicts and while the multi-cycle multiply/divide unit is busy. It generalises fixed-depth decode forwarding to NSTAGE producer stages, configurable widths, and HI/LO busy tracking.

## Interface
- DW, 32, data width
- AW, 5, register address width (2^AW registers; register 0 hard-wired zero)
- NSTAGE, 3, producer stages after D (1=E … NSTAGE=W)
- MUL_LAT, 5, multiply busy cycles
- DIV_LAT, 10, divide busy cycles

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- d_valid  in  1  D holds a real instruction
- d_rs, d_rt  in  AW  source register addresses
- d_rs_use, d_rt_use  in  1  operand actually read
- d_rs_tuse, d_rt_tuse  in  2  cycles until the operand is consumed (0 = in D)
- d_dst  in  AW  destination register (0 = none)
- d_tnew  in  2  Tnew when the instruction sits in E
- d_md  in  1  instruction uses HI/LO or the MD unit
- d_md_start, d_md_div  in  1  starts mult (div when d_md_div=1)
- fwd_data  in  NSTAGE*DW  result bus of stage s at bits [s*DW-1:(s-1)*DW]
- w_we  in  1  GRF write enable
- w_addr  in  AW  GRF write address
- w_data  in  DW  GRF write data
- rs_data, rt_data  out  DW  operand values
- stall  out  1  hold F/D and insert a bubble into E
- md_busy  out  1  MD counter non-zero

## Operation
- GRF: 2^AW×DW. Synchronous write on posedge when w_we && w_addr!=0. Combinational read.
- Same-cycle write-through: if w_we && w_addr==d_rs && d_rs!=0, the GRF path returns w_data.
- Scoreboard: entries sb[1..NSTAGE], each {valid, dst, tnew}.
- Each posedge, sb[s+1] <= sb[s] with tnew <= (tnew==0 ? 0 : tnew-1).
- The sb[NSTAGE] entry is discarded.
- sb[1] <= {1, d_dst, d_tnew} if d_valid && !stall && d_dst!=0. Otherwise sb[1] <= bubble (valid=0).
- Match for rs: valid && dst==d_rs && d_rs!=0. The lowest s (youngest) wins.
- rs_data source:
  - youngest match with tnew==0: fwd_data stage s
  - no match: GRF/write-through path
  - youngest match with tnew>0: GRF value, don't-care (downstream forwarding covers it)
- rt uses the same rules.
- Register 0: never matches, always reads 0.
- Data stall: d_valid && d_rs_use && youngest rs match with tnew > d_rs_tuse. The rt condition is identical; the two are ORed.
- MD counter md_cnt, width ceil(log2(DIV_LAT+1)):
  - if d_valid && d_md_start && !stall: load DIV_LAT when d_md_div, else MUL_LAT
  - otherwise decrement when non-zero
- md_busy = (md_cnt!=0).
- MD stall: d_valid && d_md && md_busy.
- stall = data stall | MD stall.
- When stall=1, D state does not enter the scoreboard and no MD start is accepted.

## Timing
- rs_data, rt_data, stall and md_busy are combinational from inputs and state. There is no output latency.
- Reset asserted (any time, including mid-stall or mid-MD):
  - all sb entries invalid, md_cnt=0, GRF all zero
  - stall=0, md_busy=0; rs_data/rt_data read 0 unless w_data is written through
- A load (d_tnew=2) followed by a use with Tuse=0 gives exactly 2 stall cycles. The operand then comes from stage 3.
- An ALU result (d_tnew=1) followed by Tuse=0 gives 1 stall cycle, then the operand comes from stage 2. With Tuse>=1 there is no stall.
- MD start accepted at edge k: md_busy is high for edges k+1 … k+LAT, i.e. LAT cycles.
- A dependent d_md is released in the cycle md_busy falls.
- A new start while busy is impossible, because d_md_start implies d_md, which stalls.
- Simultaneous w_we and a scoreboard match: the scoreboard forward wins over write-through.
- Unused d_rs_use/d_rt_use never cause a stall.

## Test plan
- Reset, then read r5 with no writes → rs_data=0, stall=0, md_busy=0. Assert reset mid-MD (md_cnt=3) → md_busy=0 immediately.
- Issue dst=8 tnew=2, then rs=8 tuse=0, fwd_data stage3=0xCAFE0001 → stall=1,1 then 0 with rs_data=0xCAFE0001.
- Issue dst=9 tnew=1, then rt=9 tuse=1 → no stall. Repeat with tuse=0 → one stall, then rt_data=fwd_data stage2=0x00001234.
- Issue dst=7 twice (older tnew=0 at s=2, younger tnew=0 at s=1), then rs=7 → rs_data from stage 1. Also dst=0 then rs=0 → no stall, rs_data=0.
- w_we=1, w_addr=3, w_data=0xDEADBEEF, and rs=3 in the same cycle with no match → rs_data=0xDEADBEEF. Next cycle the GRF holds it.
- mult start, then mfhi (d_md) → md_busy 5 cycles, stall 5 cycles. Repeat with div → 10 cycles.
